// File: rtl/sync_frame_tx_110110_if.sv
// Handshake and serial-line bundle for the 110110 frame transmitter.
//   data_in  : payload word, sampled only when valid_in && ready
//   valid_in : payload present
//   ready    : transmitter idle and able to accept
//   out      : registered serial line, idles at 0
//   busy     : frame in progress (sync, data or gap)
//   done     : one-cycle pulse after the last payload bit
interface sync_frame_tx_110110_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data_in;
   logic              valid_in;
   logic              ready;
   logic              out;
   logic              busy;
   logic              done;

   modport master (
      output data_in, valid_in,
      input  ready, out, busy, done
   );

   modport slave (
      input  data_in, valid_in,
      output ready, out, busy, done
   );
endinterface

// File: rtl/sync_frame_tx_110110.sv
// Serial frame transmitter for the 110110 sync-word link.
// Accepts a payload word over valid/ready, then sends SYNC_PAT MSB-first,
// the payload MSB-first and GAP_BITS forced-0 bit periods; each bit is held
// BIT_CYC clocks. No bit stuffing: payload content that looks like the sync
// word is sent as-is.
// Ports:
//   clk   : system clock, everything on posedge
//   reset : synchronous, active-high
//   bus   : slave side of sync_frame_tx_110110_if (data_in, valid_in,
//           ready, out, busy, done)
//
// state | meaning
// IDLE  | line at 0, ready for a payload
// SYNC  | shifting out the sync word
// DATA  | shifting out the captured payload
// GAP   | forced-0 idle gap before returning to IDLE
module sync_frame_tx_110110 #(
   parameter int                SYNC_W   = 6,
   parameter logic [SYNC_W-1:0] SYNC_PAT = 6'b110110,
   parameter int                DATA_W   = 8,
   parameter int                BIT_CYC  = 1,
   parameter int                GAP_BITS = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   sync_frame_tx_110110_if.slave   bus
);
   localparam int BW = $clog2(SYNC_W + DATA_W + GAP_BITS + 1);
   localparam int CW = $clog2(BIT_CYC + 1);

   typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

   state_t            state;
   logic [DATA_W-1:0] data_sh;
   logic [SYNC_W-1:0] sync_sh;
   logic [BW-1:0]     bit_cnt;
   logic [CW-1:0]     cyc_cnt;
   logic              out_r;
   logic              done_r;
   logic              bit_end;

   // last clock of the current bit period
   assign bit_end = (cyc_cnt == CW'(BIT_CYC - 1));

   assign bus.ready = (state == IDLE);
   assign bus.busy  = (state != IDLE);
   assign bus.out   = out_r;
   assign bus.done  = done_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         data_sh <= '0;
         sync_sh <= '0;
         bit_cnt <= '0;
         cyc_cnt <= '0;
         out_r   <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               out_r   <= 1'b0;
               bit_cnt <= '0;
               cyc_cnt <= '0;
               if (bus.valid_in) begin
                  data_sh <= bus.data_in;
                  // first sync bit goes straight to the line; the rest queue up
                  out_r   <= SYNC_PAT[SYNC_W-1];
                  sync_sh <= SYNC_PAT << 1;
                  state   <= SYNC;
               end
            end

            SYNC: begin
               if (!bit_end) begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end else begin
                  cyc_cnt <= '0;
                  if (bit_cnt == BW'(SYNC_W - 1)) begin
                     bit_cnt <= '0;
                     out_r   <= data_sh[DATA_W-1];
                     data_sh <= data_sh << 1;
                     state   <= DATA;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                     out_r   <= sync_sh[SYNC_W-1];
                     sync_sh <= sync_sh << 1;
                  end
               end
            end

            DATA: begin
               if (!bit_end) begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end else begin
                  cyc_cnt <= '0;
                  if (bit_cnt == BW'(DATA_W - 1)) begin
                     bit_cnt <= '0;
                     out_r   <= 1'b0;
                     done_r  <= 1'b1;
                     state   <= (GAP_BITS == 0) ? IDLE : GAP;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                     out_r   <= data_sh[DATA_W-1];
                     data_sh <= data_sh << 1;
                  end
               end
            end

            GAP: begin
               out_r <= 1'b0;
               if (!bit_end) begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end else begin
                  cyc_cnt <= '0;
                  if (bit_cnt == BW'(GAP_BITS - 1)) begin
                     bit_cnt <= '0;
                     state   <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end

            default: begin
               out_r <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sync_frame_tx_110110.sv
// Bench for sync_frame_tx_110110: three instances (defaults, BIT_CYC=3,
// GAP_BITS=0) checked every cycle against a frame-position model, plus
// hand-computed literal expectations for the directed scenarios.
module tb_sync_frame_tx_110110;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sync_frame_tx_110110_if #(.DATA_W(8)) b0();
   sync_frame_tx_110110_if #(.DATA_W(8)) b1();
   sync_frame_tx_110110_if #(.DATA_W(8)) b2();

   sync_frame_tx_110110 #(.BIT_CYC(1), .GAP_BITS(2)) dut0 (.clk(clk), .reset(reset), .bus(b0));
   sync_frame_tx_110110 #(.BIT_CYC(3), .GAP_BITS(2)) dut1 (.clk(clk), .reset(reset), .bus(b1));
   sync_frame_tx_110110 #(.BIT_CYC(1), .GAP_BITS(0)) dut2 (.clk(clk), .reset(reset), .bus(b2));

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   logic so [0:63];
   logic sd [0:63];
   logic sr [0:63];
   logic sb [0:63];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- per-instance access ----------------
   function automatic int bc_of(int s);
      return (s == 1) ? 3 : 1;
   endfunction
   function automatic int gb_of(int s);
      return (s == 2) ? 0 : 2;
   endfunction
   function automatic logic vin(int s);
      case (s)
         0: return b0.valid_in;
         1: return b1.valid_in;
         default: return b2.valid_in;
      endcase
   endfunction
   function automatic logic [7:0] din(int s);
      case (s)
         0: return b0.data_in;
         1: return b1.data_in;
         default: return b2.data_in;
      endcase
   endfunction
   // {out, done, ready, busy}
   function automatic logic [3:0] probe(int s);
      case (s)
         0: return {b0.out, b0.done, b0.ready, b0.busy};
         1: return {b1.out, b1.done, b1.ready, b1.busy};
         default: return {b2.out, b2.done, b2.ready, b2.busy};
      endcase
   endfunction
   task automatic drive(int s, logic v, logic [7:0] d);
      case (s)
         0: begin b0.valid_in = v; b0.data_in = d; end
         1: begin b1.valid_in = v; b1.data_in = d; end
         default: begin b2.valid_in = v; b2.data_in = d; end
      endcase
   endtask

   // ---------------- behavioural model ----------------
   // A frame is a list of cycles: 14 bits of BIT_CYC cycles each (sync then
   // payload), then the gap (done on its first cycle), or with no gap a
   // single non-busy cycle that carries done.
   function automatic int flen(int bc, int gb);
      return 14 * bc + ((gb > 0) ? gb * bc : 1);
   endfunction

   // returns {out, busy, done} for cycle i of a frame
   function automatic logic [2:0] entry(logic [7:0] d, int i, int bc, int gb);
      logic [5:0] sp;
      int nb;
      sp = 6'b110110;
      if (i < 14 * bc) begin
         nb = i / bc;
         if (nb < 6) return {sp[5-nb], 1'b1, 1'b0};
         return {d[7-(nb-6)], 1'b1, 1'b0};
      end
      return {1'b0, (gb > 0), (i == 14 * bc)};
   endfunction

   int         pos [3] = '{-1, -1, -1};
   logic [7:0] md  [3];

   function automatic logic [2:0] cur(int s);
      if (pos[s] >= 0) return entry(md[s], pos[s], bc_of(s), gb_of(s));
      return 3'b000;
   endfunction
   function automatic logic accept_now(int s);
      logic [2:0] e;
      e = cur(s);
      return !reset && !e[1] && vin(s);
   endfunction
   function automatic int next_pos(int s);
      if (reset) return -1;
      if (accept_now(s)) return 0;
      if (pos[s] >= 0) return (pos[s] + 1 >= flen(bc_of(s), gb_of(s))) ? -1 : pos[s] + 1;
      return -1;
   endfunction

   always @(posedge clk) begin
      for (int s = 0; s < 3; s++) begin
         pos[s] <= next_pos(s);
         if (accept_now(s)) md[s] <= din(s);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int s = 0; s < 3; s++) begin
            logic [2:0] e;
            e = cur(s);
            chk($sformatf("model_dut%0d_t%0t", s, $time), {60'd0, probe(s)},
                {60'd0, e[2], e[0], !e[1], e[1]});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(int s, logic [7:0] d, bit hold);
      @(negedge clk);
      drive(s, 1'b1, d);
      @(posedge clk);
      #1;
      if (!hold) drive(s, 1'b0, d);
   endtask

   // sample index i = cycle k+i after acceptance at edge k
   task automatic capture(int s, int a, int b);
      for (int i = a; i <= b; i++) begin
         @(negedge clk);
         {so[i], sd[i], sr[i], sb[i]} = probe(s);
      end
   endtask

   function automatic logic [63:0] pack_o(int a, int b);
      logic [63:0] r;
      r = '0;
      for (int i = a; i <= b; i++) r = {r[62:0], so[i]};
      return r;
   endfunction
   function automatic logic [63:0] pack_d(int a, int b);
      logic [63:0] r;
      r = '0;
      for (int i = a; i <= b; i++) r = {r[62:0], sd[i]};
      return r;
   endfunction

   // overlapping 110110 detector looped back on cycles 1..14 (idle 0 before)
   function automatic logic [63:0] det_mask();
      logic [63:0] m;
      logic [5:0]  sp;
      logic        hit;
      int          idx;
      sp = 6'b110110;
      m  = '0;
      for (int c = 1; c <= 14; c++) begin
         hit = 1'b1;
         for (int j = 0; j < 6; j++) begin
            idx = c - 5 + j;
            if (((idx < 1) ? 1'b0 : so[idx]) !== sp[5-j]) hit = 1'b0;
         end
         m[c] = hit;
      end
      return m;
   endfunction

   // ---------------- directed scenarios ----------------
   initial begin
      logic [3:0] p;
      reset = 1'b1;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      drive(2, 1'b0, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++)
         chk($sformatf("reset_state_dut%0d", s), {60'd0, probe(s)}, 64'b0010);
      reset  = 1'b0;
      chk_en = 1'b1;

      // defaults, 8'hA5
      send(0, 8'hA5, 1'b0);
      capture(0, 1, 17);
      chk("a5_stream", pack_o(1, 14), 64'b11011010100101);
      chk("a5_gap_out", pack_o(15, 16), 64'b00);
      chk("a5_done", pack_d(1, 17), 64'b00000000000000100);
      chk("a5_ready_k16", {63'd0, sr[16]}, 64'd0);
      chk("a5_ready_k17", {63'd0, sr[17]}, 64'd1);
      chk("a5_detector", det_mask(), 64'h40);

      // 8'hDB aliases the sync word
      send(0, 8'hDB, 1'b0);
      capture(0, 1, 17);
      chk("db_stream", pack_o(1, 14), 64'b11011011011011);
      chk("db_detector", det_mask(), 64'h1240);

      // BIT_CYC=3, 8'h00
      send(1, 8'h00, 1'b0);
      capture(1, 1, 49);
      chk("bc3_sync", pack_o(1, 18), 64'b111111000111111000);
      chk("bc3_data_gap", pack_o(19, 49), 64'd0);
      chk("bc3_busy_k42", {63'd0, sb[42]}, 64'd1);
      chk("bc3_done", pack_d(1, 49), 64'd64);
      chk("bc3_ready_k48", {63'd0, sr[48]}, 64'd0);
      chk("bc3_ready_k49", {63'd0, sr[49]}, 64'd1);

      // valid held high, data changes right after acceptance
      send(0, 8'h5A, 1'b1);
      drive(0, 1'b1, 8'hC3);
      capture(0, 1, 31);
      drive(0, 1'b0, 8'h00);
      chk("hold_first_stream", pack_o(1, 14), 64'b11011001011010);
      chk("hold_idle_ready", {62'd0, sr[17], sb[17]}, 64'b10);
      chk("hold_second_start", {62'd0, so[18], sb[18]}, 64'b11);
      chk("hold_second_stream", pack_o(18, 31), 64'b11011011000011);
      repeat (8) @(negedge clk);

      // reset during DATA, new frame in the following cycle
      send(0, 8'h96, 1'b0);
      capture(0, 1, 8);
      reset = 1'b1;
      drive(0, 1'b1, 8'h3C);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      p = probe(0);
      chk("rst_mid_idle", {60'd0, p}, 64'b0010);
      @(posedge clk);
      #1 drive(0, 1'b0, 8'h00);
      capture(0, 1, 14);
      chk("rst_new_stream", pack_o(1, 14), 64'b11011000111100);
      repeat (4) @(negedge clk);

      // reset and valid together while idle: no acceptance
      reset = 1'b1;
      drive(0, 1'b1, 8'h77);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(0, 1'b0, 8'h00);
      @(negedge clk);
      p = probe(0);
      chk("rst_wins", {60'd0, p}, 64'b0010);

      // GAP_BITS=0, back-to-back acceptance in the done cycle
      send(2, 8'hFF, 1'b0);
      capture(2, 1, 15);
      chk("g0_stream", pack_o(1, 14), 64'b11011011111111);
      chk("g0_k15", {60'd0, so[15], sd[15], sr[15], sb[15]}, 64'b0110);
      drive(2, 1'b1, 8'h81);
      @(posedge clk);
      #1 drive(2, 1'b0, 8'h00);
      capture(2, 16, 16);
      chk("g0_next_start", {62'd0, so[16], sb[16]}, 64'b11);
      repeat (20) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
